wb_stage_multi: RTL
===================

Name: wb_stage_multi

Overview:
- Parametrised multi-lane writeback stage, successor to the fixed two-result writeback block.
- Accepts up to LANES results per cycle. Each lane selects its ALU or memory value by its own mem_read bit.
- Results go into an in-order writeback buffer. The buffer drains up to WR_PORTS entries per cycle into the integrated register file.
- Decode reads the register file through RD_PORTS read ports, each with a pending flag for writes still in the buffer.

Parameters:
WIDTH, 32, data width of results and registers
NREGS, 32, number of architectural registers; register 0 is hardwired zero
LANES, 2, result lanes accepted per cycle
WR_PORTS, 1, register-file writes retired per cycle (1..LANES)
DEPTH, 8, writeback buffer entries (power of two, >= LANES)
RD_PORTS, 2, combinational read ports

Ports:
clock  in  1  single clock; all state updates on its rising edge
reset_n  in  1  asynchronous, active-low reset
in_valid  in  LANES  per-lane result valid
in_mem_read  in  LANES  per lane: 1 selects memory_out, 0 selects result_alu
in_result_alu  in  LANES*WIDTH  ALU results; lane i at bits [i*WIDTH +: WIDTH]
in_memory_out  in  LANES*WIDTH  load data, same packing
in_destination  in  LANES*log2(NREGS)  destination register per lane
in_ready  out  1  stage can accept a full lane group this cycle
rd_addr  in  RD_PORTS*log2(NREGS)  read addresses
rd_data  out  RD_PORTS*WIDTH  read data
rd_pending  out  RD_PORTS  buffered, unretired write to rd_addr exists
result_out  out  LANES*WIDTH  muxed per-lane result (combinational, for forwarding)
buf_count  out  log2(DEPTH)+1  occupied buffer entries
retired_count  out  32  total register writes retired, wraps mod 2^32

Behaviour:
- Reset (async assert, sync-free release):
  - All registers read 0; buffer empty; buf_count=0; retired_count=0.
  - in_ready=1 after reset.
  - Reset mid-drain discards all buffered entries.
- result_out lane i = in_mem_read[i] ? in_memory_out lane i : in_result_alu lane i. Combinational, independent of in_valid.
- in_ready = (DEPTH - buf_count) >= LANES, computed from the registered count only. Same-cycle drain is not credited.
- Accept condition: in_ready=1 and any in_valid bit set. While in_ready=0, inputs are ignored and the upstream stage holds.
- Enqueue:
  - On accept, valid lanes whose destination != 0 are written in ascending lane order into consecutive tail slots (compacted).
  - Lanes with destination 0 are dropped and consume no slot.
  - Lane i is older than lane i+1.
- Drain:
  - Each cycle, n_out = min(buf_count, WR_PORTS) oldest entries are written to the register file.
  - If two entries drained in the same cycle share a destination, the younger value wins.
- buf_count_next = buf_count + n_in - n_out. Head and tail pointers wrap modulo DEPTH. Overflow is impossible by construction; underflow cannot occur.
- retired_count increments by n_out each cycle.
- Read ports:
  - rd_data = register-file value, with no bypass from the buffer or from same-cycle writes. The write is visible on the cycle after retire.
  - Address 0 always reads 0 with rd_pending=0.
  - rd_pending = OR over occupied buffer entries of (dest == rd_addr), including entries draining this cycle.
- Latency: a result accepted in cycle t is earliest visible on rd_data at t+2 (enqueue at edge t, retire at edge t+1). Latency is longer under backlog.

Test Plan:
- Reset, then read r5 -> rd_data=0, rd_pending=0, in_ready=1, buf_count=0. Assert reset_n low mid-operation -> buf_count=0 immediately.
- LANES=2, WR_PORTS=1: lane0 alu=0x11 dst=3, lane1 mem=0xAB mem_read=1 dst=4, one cycle -> buf_count=2. rd_pending(r3)=1; r3=0x11 two cycles later; r4=0xAB one cycle after that; retired_count=2.
- Both lanes dst=7 (0x1, then 0x2), WR_PORTS=2 -> both drain in one cycle; r7=0x2.
- Lane0 dst=0 value 0xFF, lane1 invalid -> nothing enqueued; buf_count stays 0; r0 reads 0.
- Continuous 2-lane accepts with DEPTH=8, WR_PORTS=1 -> in_ready drops when buf_count reaches 7. Drains until buf_count<=6, then in_ready=1. No entry lost; retired values are in order.
- retired_count preset near wrap (force 0xFFFFFFFF) then one retire -> reads 0.

Source files
------------

// File: rtl/wb_stage_multi.sv
`default_nettype none
// ============================================================================
// Module   : wb_stage_multi
// Purpose  : Multi-lane writeback stage. Results from up to LANES lanes are
//            compacted into an in-order buffer, which drains up to WR_PORTS
//            entries per cycle into an integrated register file. Decode
//            reads the file through RD_PORTS combinational ports, each with
//            a flag for writes still waiting in the buffer.
// Revision : 1.0 - initial release
// ============================================================================
module wb_stage_multi #(
    parameter int WIDTH    = 32,
    parameter int NREGS    = 32,
    parameter int LANES    = 2,
    parameter int WR_PORTS = 1,
    parameter int DEPTH    = 8,
    parameter int RD_PORTS = 2
) (
    input  logic                             clock,
    input  logic                             reset_n,
    input  logic [LANES-1:0]                 in_valid,
    input  logic [LANES-1:0]                 in_mem_read,
    input  logic [LANES*WIDTH-1:0]           in_result_alu,
    input  logic [LANES*WIDTH-1:0]           in_memory_out,
    input  logic [LANES*$clog2(NREGS)-1:0]   in_destination,
    output logic                             in_ready,
    input  logic [RD_PORTS*$clog2(NREGS)-1:0] rd_addr,
    output logic [RD_PORTS*WIDTH-1:0]        rd_data,
    output logic [RD_PORTS-1:0]              rd_pending,
    output logic [LANES*WIDTH-1:0]           result_out,
    output logic [$clog2(DEPTH):0]           buf_count,
    output logic [31:0]                      retired_count
);

    localparam int AW = $clog2(NREGS);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // Buffer storage (no reset needed: occupancy is tracked by r_count)
    logic [AW-1:0]    r_buf_dst  [DEPTH];
    logic [WIDTH-1:0] r_buf_data [DEPTH];
    logic [PW-1:0]    r_head;
    logic [PW-1:0]    r_tail;
    logic [CW-1:0]    r_count;
    logic [31:0]      r_retired;
    logic [WIDTH-1:0] r_regs [NREGS];

    logic [WIDTH-1:0] w_lane_val  [LANES];
    logic [LANES-1:0] w_keep;
    logic [PW-1:0]    w_slot      [LANES];
    logic [CW-1:0]    w_n_in;
    logic [CW-1:0]    w_n_out;
    logic [PW-1:0]    w_drain_slot [WR_PORTS];
    logic             w_accept;

    // Readiness uses registered occupancy only; same-cycle drain is not credited
    assign in_ready      = (CW'(DEPTH) - r_count) >= CW'(LANES);
    assign w_accept      = in_ready && (|in_valid);
    assign buf_count     = r_count;
    assign retired_count = r_retired;

    // Per-lane ALU/memory select, also exported for forwarding
    always_comb begin
        result_out = '0;
        for (int i = 0; i < LANES; i++) begin
            w_lane_val[i] = in_mem_read[i] ? in_memory_out[i*WIDTH +: WIDTH]
                                           : in_result_alu[i*WIDTH +: WIDTH];
            result_out[i*WIDTH +: WIDTH] = w_lane_val[i];
        end
    end

    // Compaction: kept lanes take consecutive tail slots in lane order
    always_comb begin
        w_n_in = '0;
        for (int i = 0; i < LANES; i++) begin
            w_keep[i] = w_accept && in_valid[i]
                        && (in_destination[i*AW +: AW] != '0);
            w_slot[i] = r_tail + w_n_in[PW-1:0];
            if (w_keep[i]) begin
                w_n_in = w_n_in + CW'(1);
            end
        end
    end

    // Number of oldest entries retired this cycle and their slots
    always_comb begin
        w_n_out = (r_count > CW'(WR_PORTS)) ? CW'(WR_PORTS) : r_count;
        for (int k = 0; k < WR_PORTS; k++) begin
            w_drain_slot[k] = r_head + PW'(k);
        end
    end

    // Read ports: plain register-file read plus pending scan of occupied slots
    always_comb begin
        rd_data    = '0;
        rd_pending = '0;
        for (int p = 0; p < RD_PORTS; p++) begin
            logic [AW-1:0] addr;
            logic [PW-1:0] age;
            logic          pend;
            addr = rd_addr[p*AW +: AW];
            age  = '0;
            pend = 1'b0;
            for (int j = 0; j < DEPTH; j++) begin
                age = PW'(j) - r_head;
                if ((CW'(age) < r_count) && (r_buf_dst[j] == addr)) begin
                    pend = 1'b1;
                end
            end
            if (addr == '0) begin
                rd_data[p*WIDTH +: WIDTH] = '0;
                rd_pending[p]             = 1'b0;
            end else begin
                rd_data[p*WIDTH +: WIDTH] = r_regs[addr];
                rd_pending[p]             = pend;
            end
        end
    end

    // Buffer payload write for accepted lanes
    always_ff @(posedge clock) begin
        for (int i = 0; i < LANES; i++) begin
            if (w_keep[i]) begin
                r_buf_dst[w_slot[i]]  <= in_destination[i*AW +: AW];
                r_buf_data[w_slot[i]] <= w_lane_val[i];
            end
        end
    end

    // Pointers, occupancy, retire counter and register file; later (younger)
    // drain writes override earlier ones to the same register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_head    <= '0;
            r_tail    <= '0;
            r_count   <= '0;
            r_retired <= '0;
            for (int r = 0; r < NREGS; r++) begin
                r_regs[r] <= '0;
            end
        end else begin
            r_head    <= r_head + w_n_out[PW-1:0];
            r_tail    <= r_tail + w_n_in[PW-1:0];
            r_count   <= r_count + w_n_in - w_n_out;
            r_retired <= r_retired + 32'(w_n_out);
            for (int k = 0; k < WR_PORTS; k++) begin
                if (CW'(k) < r_count) begin
                    r_regs[r_buf_dst[w_drain_slot[k]]] <= r_buf_data[w_drain_slot[k]];
                end
            end
        end
    end

endmodule
`default_nettype wire
